// File: rtl/i2c_resp_pkg.sv
// Shared types and constants for the single-address I2C responder.
package i2c_resp_pkg;

  localparam int unsigned I2C_ADDR_WIDTH = 7;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    WR_DATA   = 3'd3,
    WR_ACK    = 3'd4,
    RD_DATA   = 3'd5,
    RD_ACK    = 3'd6,
    WAIT_STOP = 3'd7
  } i2c_resp_state_t;

  typedef enum logic {
    I2C_WRITE = 1'b0,
    I2C_READ  = 1'b1
  } i2c_op_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer plus history flop for one I2C line; resets to idle-high.
module i2c_line_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic r_meta;
  logic r_sync;
  logic r_hist;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_hist <= 1'b1;
    end else begin
      r_meta <= line_i;
      r_sync <= r_meta;
      r_hist <= r_sync;
    end
  end

  assign sync_o = r_sync;
  assign rise_o = r_sync & ~r_hist;
  assign fall_o = ~r_sync & r_hist;

endmodule

// File: rtl/i2c_slave_responder.sv
// Oversampled single-address I2C slave: write bytes out as pulses, read bytes in by request/data handshake.
module i2c_slave_responder
  import i2c_resp_pkg::*;
#(
  parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR = 7'h22,
  parameter int unsigned               DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  wr_valid_o,
  output logic                  rd_req_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  busy_o
);

  if (DATA_WIDTH != 8) begin : g_width_chk
    $error("i2c_slave_responder: DATA_WIDTH must be 8");
  end

  logic w_scl_s, w_scl_rise, w_scl_fall;
  logic w_sda_s, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;

  i2c_line_sync u_scl_sync (
    .clk_i (clk_i), .rst_i (rst_i), .line_i (scl_i),
    .sync_o(w_scl_s), .rise_o(w_scl_rise), .fall_o(w_scl_fall)
  );

  i2c_line_sync u_sda_sync (
    .clk_i (clk_i), .rst_i (rst_i), .line_i (sda_i),
    .sync_o(w_sda_s), .rise_o(w_sda_rise), .fall_o(w_sda_fall)
  );

  assign w_start = w_sda_fall & w_scl_s;
  assign w_stop  = w_sda_rise & w_scl_s;

  i2c_resp_state_t r_state;
  i2c_op_t         r_rw;
  logic [7:0]      r_shift;
  logic [2:0]      r_bitcnt;
  logic            r_full;   // 8th bit of the current byte has been sampled
  logic [1:0]      r_ld;     // read-byte fetch: 1 = req cycle, 2 = load, 3 = drive MSB
  logic            r_sda;
  logic [7:0]      r_wr_data;
  logic            r_wr_valid;
  logic            r_rd_req;
  logic            r_busy;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state    <= IDLE;
      r_rw       <= I2C_WRITE;
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_full     <= 1'b0;
      r_ld       <= '0;
      r_sda      <= 1'b1;
      r_wr_data  <= '0;
      r_wr_valid <= 1'b0;
      r_rd_req   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_wr_valid <= 1'b0;
      r_rd_req   <= 1'b0;
      if (w_start) begin
        r_state  <= ADDR;
        r_bitcnt <= '0;
        r_full   <= 1'b0;
        r_ld     <= '0;
        r_sda    <= 1'b1;
        r_busy   <= 1'b0;
      end else if (w_stop && r_state != IDLE) begin
        r_state  <= IDLE;
        r_bitcnt <= '0;
        r_full   <= 1'b0;
        r_ld     <= '0;
        r_sda    <= 1'b1;
        r_busy   <= 1'b0;
      end else begin
        case (r_ld)
          2'd1:    r_ld <= 2'd2;
          2'd2: begin
            r_shift <= rd_data_i;
            r_ld    <= 2'd3;
          end
          2'd3: begin
            r_sda <= r_shift[7];
            r_ld  <= 2'd0;
          end
          default: ;
        endcase

        case (r_state)
          ADDR, WR_DATA: begin
            if (w_scl_rise) begin
              r_shift  <= {r_shift[6:0], w_sda_s};
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) begin
                r_full <= 1'b1;
                if (r_state == WR_DATA) begin
                  r_wr_data  <= {r_shift[6:0], w_sda_s};
                  r_wr_valid <= 1'b1;
                end
              end
            end else if (w_scl_fall && r_full) begin
              r_full <= 1'b0;
              if (r_state == WR_DATA) begin
                r_sda   <= 1'b0;
                r_state <= WR_ACK;
              end else if (r_shift[7:1] == SLAVE_ADDR) begin
                r_sda   <= 1'b0;
                r_busy  <= 1'b1;
                r_rw    <= i2c_op_t'(r_shift[0]);
                r_state <= ADDR_ACK;
              end else begin
                r_state <= WAIT_STOP;
              end
            end
          end
          ADDR_ACK: begin
            if (w_scl_fall) begin
              r_sda <= 1'b1;
              if (r_rw == I2C_READ) begin
                r_rd_req <= 1'b1;
                r_ld     <= 2'd1;
                r_bitcnt <= '0;
                r_state  <= RD_DATA;
              end else begin
                r_state <= WR_DATA;
              end
            end
          end
          WR_ACK: begin
            if (w_scl_fall) begin
              r_sda   <= 1'b1;
              r_state <= WR_DATA;
            end
          end
          RD_DATA: begin
            if (w_scl_fall) begin
              if (r_bitcnt == 3'd7) begin
                r_sda   <= 1'b1;
                r_state <= RD_ACK;
              end else begin
                r_shift <= {r_shift[6:0], 1'b0};
                r_sda   <= r_shift[6];
              end
              r_bitcnt <= r_bitcnt + 3'd1;
            end
          end
          RD_ACK: begin
            if (w_scl_rise && w_sda_s) begin
              r_state <= WAIT_STOP;
            end else if (w_scl_fall) begin
              r_rd_req <= 1'b1;
              r_ld     <= 2'd1;
              r_bitcnt <= '0;
              r_state  <= RD_DATA;
            end
          end
          default: r_sda <= 1'b1;
        endcase
      end
    end
  end

  assign sda_o      = r_sda;
  assign wr_data_o  = r_wr_data;
  assign wr_valid_o = r_wr_valid;
  assign rd_req_o   = r_rd_req;
  assign busy_o     = r_busy;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bit-banged I2C master against the responder with write/read byte scoreboards.
module tb_i2c_slave_responder;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m_scl;
  logic       m_sda;
  logic [7:0] rd_data;
  logic       sda_o;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       rd_req;
  logic       busy;
  logic       sda_line;

  always #5 clk = ~clk;

  // Open-drain bus: either side pulling low wins, released line reads high.
  assign sda_line = m_sda & sda_o;

  i2c_slave_responder #(.SLAVE_ADDR(7'h22), .DATA_WIDTH(8)) dut (
    .clk_i     (clk),
    .rst_i     (rst_n),
    .scl_i     (m_scl),
    .sda_i     (sda_line),
    .sda_o     (sda_o),
    .wr_data_o (wr_data),
    .wr_valid_o(wr_valid),
    .rd_req_o  (rd_req),
    .rd_data_i (rd_data),
    .busy_o    (busy)
  );

  int         n_vec = 0;
  int         n_err = 0;
  int         wr_pulses = 0;
  int         rd_pulses = 0;
  int         rd_phase = 0;
  logic [7:0] exp_wr[$];
  logic [7:0] exp_rd[$];
  logic [7:0] rd_src[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write scoreboard: every wr_valid pulse must match the next byte the master sent.
  always @(negedge clk) begin
    if (wr_valid) begin
      wr_pulses++;
      check_val("wr_pending", 32'(exp_wr.size() > 0), 1);
      if (exp_wr.size() > 0) check_val("wr_data", wr_data, exp_wr.pop_front());
    end
  end

  // Read source: garbage except in the one cycle where the DUT should sample (req+2).
  always @(negedge clk) begin
    if (rd_req) begin
      rd_pulses++;
      rd_phase = 1;
      rd_data  = (rd_src.size() > 0) ? ~rd_src[0] : 8'h00;
    end else if (rd_phase == 1) begin
      if (rd_src.size() > 0) begin
        rd_data = rd_src.pop_front();
        exp_rd.push_back(rd_data);
      end
      rd_phase = 2;
    end else if (rd_phase == 2) begin
      rd_data  = ~rd_data;
      rd_phase = 0;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    m_sda = 1'b1; wait_clk(Q);
  endtask

  task automatic write_bit(input logic b);
    m_sda = b;    wait_clk(Q);
    m_scl = 1'b1; wait_clk(2 * Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    b = sda_line; wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, input logic exp_ack, input string tag);
    logic ack;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
    check_val(tag, ack, exp_ack);
  endtask

  task automatic read_byte(input logic nack);
    logic [7:0] d;
    logic       b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
    check_val("rd_pending", 32'(exp_rd.size() > 0), 1);
    if (exp_rd.size() > 0) check_val("rd_byte", d, exp_rd.pop_front());
  endtask

  initial begin
    int   w0;
    int   r0;
    logic b;
    rst_n   = 1'b0;
    m_scl   = 1'b1;
    m_sda   = 1'b1;
    rd_data = 8'h00;
    wait_clk(5);
    check_val("rst_sda", sda_o, 1'b1);
    check_val("rst_wr_data", wr_data, 8'h00);
    check_val("rst_wr_valid", wr_valid, 1'b0);
    check_val("rst_rd_req", rd_req, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    wait_clk(10);

    // Two-byte write to our address
    w0 = wr_pulses;
    exp_wr.push_back(8'h55);
    exp_wr.push_back(8'hAA);
    bus_start();
    write_byte({7'h22, 1'b0}, 1'b0, "wr_addr_ack");
    check_val("wr_busy", busy, 1'b1);
    write_byte(8'h55, 1'b0, "wr_d0_ack");
    write_byte(8'hAA, 1'b0, "wr_d1_ack");
    check_val("wr_last_data", wr_data, 8'hAA);
    bus_stop();
    wait_clk(10);
    check_val("wr_busy_stop", busy, 1'b0);
    check_val("wr_pulse_cnt", wr_pulses - w0, 2);

    // Foreign address is NACKed and ignored
    w0 = wr_pulses;
    r0 = rd_pulses;
    bus_start();
    write_byte({7'h23, 1'b0}, 1'b1, "nack_addr");
    check_val("nack_busy", busy, 1'b0);
    write_byte(8'h00, 1'b1, "nack_data");
    bus_stop();
    wait_clk(10);
    check_val("nack_wr_cnt", wr_pulses - w0, 0);
    check_val("nack_rd_cnt", rd_pulses - r0, 0);

    // Two-byte read, ACK then NACK
    r0 = rd_pulses;
    rd_src.push_back(8'h3C);
    rd_src.push_back(8'hC3);
    bus_start();
    write_byte({7'h22, 1'b1}, 1'b0, "rd_addr_ack");
    check_val("rd_busy", busy, 1'b1);
    read_byte(1'b0);
    read_byte(1'b1);
    bus_stop();
    wait_clk(10);
    check_val("rd_req_cnt", rd_pulses - r0, 2);
    check_val("rd_busy_stop", busy, 1'b0);

    // Write then repeated START into a read
    w0 = wr_pulses;
    exp_wr.push_back(8'h10);
    rd_src.push_back(8'h7E);
    bus_start();
    write_byte({7'h22, 1'b0}, 1'b0, "rs_waddr_ack");
    write_byte(8'h10, 1'b0, "rs_wdata_ack");
    bus_start();
    check_val("rs_busy_clear", busy, 1'b0);
    write_byte({7'h22, 1'b1}, 1'b0, "rs_raddr_ack");
    read_byte(1'b1);
    bus_stop();
    wait_clk(10);
    check_val("rs_wr_cnt", wr_pulses - w0, 1);

    // Reset during the 4th bit of a read while the slave pulls SDA low
    rd_src.push_back(8'hE5);
    bus_start();
    write_byte({7'h22, 1'b1}, 1'b0, "mr_addr_ack");
    for (int i = 0; i < 3; i++) begin
      read_bit(b);
      check_val("mr_bit", b, 1'b1);
    end
    check_val("mr_pre_sda", sda_o, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_val("mr_sda", sda_o, 1'b1);
    check_val("mr_wr_data", wr_data, 8'h00);
    check_val("mr_wr_valid", wr_valid, 1'b0);
    check_val("mr_rd_req", rd_req, 1'b0);
    check_val("mr_busy", busy, 1'b0);
    rst_n = 1'b1;
    exp_rd.delete();
    bus_stop();
    wait_clk(10);
    w0 = wr_pulses;
    exp_wr.push_back(8'h99);
    bus_start();
    write_byte({7'h22, 1'b0}, 1'b0, "mr_waddr_ack");
    write_byte(8'h99, 1'b0, "mr_wdata_ack");
    bus_stop();
    wait_clk(10);
    check_val("mr_wr_cnt", wr_pulses - w0, 1);

    // START immediately followed by STOP, then a normal write
    w0 = wr_pulses;
    r0 = rd_pulses;
    bus_start();
    bus_stop();
    wait_clk(20);
    check_val("ss_wr_cnt", wr_pulses - w0, 0);
    check_val("ss_rd_cnt", rd_pulses - r0, 0);
    check_val("ss_busy", busy, 1'b0);
    exp_wr.push_back(8'h5A);
    bus_start();
    write_byte({7'h22, 1'b0}, 1'b0, "ss_waddr_ack");
    write_byte(8'h5A, 1'b0, "ss_wdata_ack");
    bus_stop();
    wait_clk(10);
    check_val("ss_wr_after", wr_pulses - w0, 1);

    check_val("wr_drain", exp_wr.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
